// File: rtl/knn_topk_sorter.sv
// knn_topk_sorter
//   Streaming top-K selector. Takes one (squared distance, vertex id) candidate
//   per cycle and keeps the K smallest in a sorted register array. Slot 0 holds
//   the smallest. When the query's final candidate arrives, the list is drained
//   in ascending order over a valid/ready stream.
//
// Ports
//   clk_in, rst_in              clock, synchronous active-high reset
//   clear_in                    abort query, empty list, back to FILL
//   data_valid_in/_ready_out    candidate handshake (ready only in FILL)
//   distance_sq_in, vertex_id_in, last_in   candidate payload
//   result_valid_out/_ready_in  result stream handshake
//   result_distance_out, result_id_out, result_last_out   result beat
//   count_out                   occupied slots
//   done_out                    one-cycle pulse after a drain completes
module knn_topk_sorter #(
  parameter int K        = 8,
  parameter int ID_WIDTH = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   clear_in,
  input  logic                   data_valid_in,
  input  logic [31:0]            distance_sq_in,
  input  logic [ID_WIDTH-1:0]    vertex_id_in,
  input  logic                   last_in,
  output logic                   data_ready_out,
  output logic                   result_valid_out,
  input  logic                   result_ready_in,
  output logic [31:0]            result_distance_out,
  output logic [ID_WIDTH-1:0]    result_id_out,
  output logic                   result_last_out,
  output logic [$clog2(K+1)-1:0] count_out,
  output logic                   done_out
);
  localparam int CW = $clog2(K+1);
  localparam int IW = $clog2(K);
  localparam logic [CW-1:0] KC = CW'(K);

  typedef enum logic [1:0] {S_FILL, S_DRAIN, S_DONE} state_t;

  state_t                     r_state, w_state_nxt;
  logic [K-1:0]               r_vld;
  logic [K-1:0][31:0]         r_dist;
  logic [K-1:0][ID_WIDTH-1:0] r_id;
  logic [CW-1:0]              r_cnt;
  logic [IW-1:0]              r_idx;

  logic [K-1:0]               w_gt;
  logic [K-1:0]               w_vld_nxt;
  logic [K-1:0][31:0]         w_dist_nxt;
  logic [K-1:0][ID_WIDTH-1:0] w_id_nxt;
  logic                       w_nan, w_take, w_ins, w_rlast, w_hs;

  // Exponent all-ones with non-zero mantissa; +/-Inf still passes.
  assign w_nan  = (&distance_sq_in[30:23]) && (|distance_sq_in[22:0]);
  assign w_take = (r_state == S_FILL) && data_valid_in && !clear_in;
  // With no empty or strictly-greater slot the candidate would land past K-1.
  assign w_ins  = w_take && !w_nan && (|w_gt);

  // Each slot decides on its own: keep, take the new candidate (first slot
  // that compares greater), or take its lower neighbour (shift up). Since the
  // list is sorted and packed, w_gt is a thermometer code 0..01..1.
  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_slot
      // Strict compare puts a tie after the existing equal keys.
      assign w_gt[gi] = !r_vld[gi] || (r_dist[gi][30:0] > distance_sq_in[30:0]);
      if (gi == 0) begin : g_head
        assign w_vld_nxt[gi]  = w_gt[gi] ? 1'b1           : r_vld[gi];
        assign w_dist_nxt[gi] = w_gt[gi] ? distance_sq_in : r_dist[gi];
        assign w_id_nxt[gi]   = w_gt[gi] ? vertex_id_in   : r_id[gi];
      end else begin : g_body
        assign w_vld_nxt[gi]  = !w_gt[gi] ? r_vld[gi]  :
                                !w_gt[gi-1] ? 1'b1 : r_vld[gi-1];
        assign w_dist_nxt[gi] = !w_gt[gi] ? r_dist[gi] :
                                !w_gt[gi-1] ? distance_sq_in : r_dist[gi-1];
        assign w_id_nxt[gi]   = !w_gt[gi] ? r_id[gi]   :
                                !w_gt[gi-1] ? vertex_id_in : r_id[gi-1];
      end
    end
  endgenerate

  assign w_rlast = ({{(CW-IW){1'b0}}, r_idx} == r_cnt - CW'(1));
  assign w_hs    = (r_state == S_DRAIN) && result_ready_in;

  // Slot array and occupancy.
  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in || r_state == S_DONE) begin
      r_vld <= '0;
      r_cnt <= '0;
    end else if (w_ins) begin
      r_vld  <= w_vld_nxt;
      r_dist <= w_dist_nxt;
      r_id   <= w_id_nxt;
      r_cnt  <= (r_cnt == KC) ? r_cnt : r_cnt + CW'(1);
    end
  end

  // State and read index.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_FILL;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (clear_in || r_state != S_DRAIN) r_idx <= '0;
      else if (w_hs)                      r_idx <= w_rlast ? '0 : r_idx + IW'(1);
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    data_ready_out      = 1'b0;
    result_valid_out    = 1'b0;
    result_distance_out = '0;
    result_id_out       = '0;
    result_last_out     = 1'b0;
    done_out            = 1'b0;
    count_out           = r_cnt;
    case (r_state)
      S_FILL: begin
        data_ready_out = 1'b1;
        // A dropped NaN marked last still ends the query.
        if (w_take && last_in)
          w_state_nxt = (r_cnt != '0 || w_ins) ? S_DRAIN : S_DONE;
      end
      S_DRAIN: begin
        result_valid_out    = 1'b1;
        result_distance_out = r_dist[r_idx];
        result_id_out       = r_id[r_idx];
        result_last_out     = w_rlast;
        if (result_ready_in && w_rlast) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done_out    = 1'b1;
        w_state_nxt = S_FILL;
      end
      default: w_state_nxt = S_FILL;
    endcase
    if (clear_in) w_state_nxt = S_FILL;
  end
endmodule

// File: tb/tb_knn_topk_sorter.sv
module tb_knn_topk_sorter;
  localparam int K  = 4;
  localparam int IW = 16;

  logic          clk_in = 1'b0;
  logic          rst_in, clear_in, data_valid_in, last_in, result_ready_in;
  logic [31:0]   distance_sq_in;
  logic [IW-1:0] vertex_id_in;
  logic          data_ready_out, result_valid_out, result_last_out, done_out;
  logic [31:0]   result_distance_out;
  logic [IW-1:0] result_id_out;
  logic [$clog2(K+1)-1:0] count_out;

  knn_topk_sorter #(.K(K), .ID_WIDTH(IW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .clear_in(clear_in),
    .data_valid_in(data_valid_in), .distance_sq_in(distance_sq_in),
    .vertex_id_in(vertex_id_in), .last_in(last_in),
    .data_ready_out(data_ready_out), .result_valid_out(result_valid_out),
    .result_ready_in(result_ready_in), .result_distance_out(result_distance_out),
    .result_id_out(result_id_out), .result_last_out(result_last_out),
    .count_out(count_out), .done_out(done_out)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed { logic [31:0] d; logic [IW-1:0] id; } ent_t;
  ent_t q[$];   // expected sorted top-K list

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in); #1;
  endtask

  // Reference: ordered insert by 31-bit magnitude, ties after equals, keep K.
  function automatic void mdl_push(input logic [31:0] d, input logic [IW-1:0] id);
    int   p;
    ent_t e;
    if (d[30:23] == 8'hFF && d[22:0] != 23'd0) return;
    p = q.size();
    for (int i = 0; i < q.size(); i++)
      if (q[i].d[30:0] > d[30:0]) begin p = i; break; end
    e.d = d; e.id = id;
    q.insert(p, e);
    if (q.size() > K) void'(q.pop_back());
  endfunction

  task automatic send(input logic [31:0] d, input logic [IW-1:0] id, input logic last);
    data_valid_in = 1'b1; distance_sq_in = d; vertex_id_in = id; last_in = last;
    mdl_push(d, id);
    step();
    data_valid_in = 1'b0; last_in = 1'b0;
    chk("count", 32'(count_out), 32'(q.size()));
  endtask

  task automatic chk_beat(input int b);
    chk("rvalid", 32'(result_valid_out), 32'd1);
    chk("rdist",  result_distance_out, q[b].d);
    chk("rid",    32'(result_id_out), 32'(q[b].id));
    chk("rlast",  32'(result_last_out), 32'(b == q.size() - 1));
    chk("dready_drain", 32'(data_ready_out), 32'd0);
    chk("count_drain", 32'(count_out), 32'(q.size()));
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic drain(input int mode);
    int  got = 0;
    int  cyc = 0;
    logic rdy;
    if (q.size() != 0) begin
      while (got < q.size() && cyc < 200) begin
        chk_beat(got);
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        result_ready_in = rdy;
        // Candidates offered mid-drain must be ignored.
        data_valid_in  = 1'($urandom_range(0, 1));
        distance_sq_in = 32'h3E000000;
        vertex_id_in   = 16'hBEEF;
        step();
        if (rdy) got++;
        cyc++;
      end
      chk("beats", 32'(got), 32'(q.size()));
      result_ready_in = 1'b0; data_valid_in = 1'b0;
    end
    chk("done_pulse", 32'(done_out), 32'd1);
    chk("done_novalid", 32'(result_valid_out), 32'd0);
    step();
    chk("done_once", 32'(done_out), 32'd0);
    chk("fill_ready", 32'(data_ready_out), 32'd1);
    chk("fill_count", 32'(count_out), 32'd0);
    q.delete();
  endtask

  // Abort after two beats with a candidate on the same cycle.
  task automatic abort_mid(input bit use_rst);
    send(32'h40400000, 16'd1, 1'b0);
    send(32'h3F800000, 16'd2, 1'b0);
    send(32'h40000000, 16'd3, 1'b0);
    send(32'h3F000000, 16'd4, 1'b1);
    result_ready_in = 1'b1;
    for (int b = 0; b < 2; b++) begin chk_beat(b); step(); end
    result_ready_in = 1'b0;
    if (use_rst) rst_in = 1'b1; else clear_in = 1'b1;
    data_valid_in = 1'b1; distance_sq_in = 32'h3F800000; vertex_id_in = 16'd9;
    step();
    rst_in = 1'b0; clear_in = 1'b0; data_valid_in = 1'b0;
    q.delete();
    chk("abort_ready", 32'(data_ready_out), 32'd1);
    chk("abort_count", 32'(count_out), 32'd0);
    chk("abort_valid", 32'(result_valid_out), 32'd0);
    chk("abort_done",  32'(done_out), 32'd0);
    step();
    chk("abort_done2",  32'(done_out), 32'd0);
    chk("abort_count2", 32'(count_out), 32'd0);
  endtask

  function automatic logic [31:0] rnd_dist();
    logic [31:0] d;
    case ($urandom_range(0, 9))
      0:       d = 32'h7F800001 | ($urandom & 32'h807FFFFF);   // NaN
      1:       d = 32'h7F800000;                                // +Inf
      default: begin
        d        = 32'd0;
        d[31]    = 1'($urandom_range(0, 1));
        d[30:23] = 8'(120 + $urandom_range(0, 7));
        d[22:20] = 3'($urandom_range(0, 3));
      end
    endcase
    return d;
  endfunction

  initial begin
    rst_in = 1'b1; clear_in = 1'b0; data_valid_in = 1'b0; last_in = 1'b0;
    result_ready_in = 1'b0; distance_sq_in = '0; vertex_id_in = '0;
    step(); step();
    rst_in = 1'b0;
    step();
    chk("rst_ready", 32'(data_ready_out), 32'd1);
    chk("rst_valid", 32'(result_valid_out), 32'd0);
    chk("rst_last",  32'(result_last_out), 32'd0);
    chk("rst_done",  32'(done_out), 32'd0);
    chk("rst_count", 32'(count_out), 32'd0);
    chk("rst_dist",  result_distance_out, 32'd0);
    chk("rst_id",    32'(result_id_out), 32'd0);

    // Ordering and ties.
    send(32'h40400000, 16'd1, 1'b0);
    send(32'h3F800000, 16'd2, 1'b0);
    send(32'h40000000, 16'd3, 1'b0);
    send(32'h3F800000, 16'd4, 1'b1);
    chk("tie_slot1_id", 32'(q[1].id), 32'd4);
    drain(0);

    // Overflow eviction.
    send(32'h40800000, 16'd10, 1'b0);
    send(32'h40400000, 16'd11, 1'b0);
    send(32'h40000000, 16'd12, 1'b0);
    send(32'h3F800000, 16'd13, 1'b0);
    send(32'h3F000000, 16'd14, 1'b0);
    send(32'h40A00000, 16'd15, 1'b1);
    drain(0);

    // Back-pressure.
    send(32'h41000000, 16'd20, 1'b0);
    send(32'h40E00000, 16'd21, 1'b0);
    send(32'h40C00000, 16'd22, 1'b1);
    drain(1);

    // Special values: NaN dropped, -0 first, +Inf last.
    send(32'h7FC00000, 16'd30, 1'b0);
    send(32'h80000000, 16'd31, 1'b0);
    send(32'h7F800000, 16'd32, 1'b1);
    chk("special_count", 32'(count_out), 32'd2);
    drain(0);

    // Single candidate, then NaN-last on an empty list.
    send(32'h3F800000, 16'd40, 1'b1);
    drain(2);
    send(32'h7FC00001, 16'd41, 1'b1);
    drain(0);

    abort_mid(1'b0);
    abort_mid(1'b1);

    // Randomized queries.
    for (int n = 0; n < 25; n++) begin
      int len;
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++)
        send(rnd_dist(), 16'($urandom), 1'(i == len - 1));
      drain(2);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/knn_topk_sorter.md
# knn_topk_sorter

Streaming top-K selector that sits directly downstream of `distance`. It consumes one squared-distance result per cycle, tagged with a vertex ID, and keeps the K smallest in an ascending sorted register array. When the query's final candidate arrives, it drains the K results in order over a valid/ready stream to the search controller.

## Interface
Parameters:
- `K`, 8: number of nearest candidates retained (K ≥ 2).
- `ID_WIDTH`, 16: width of the vertex ID tag.

Ports:
- `clk_in`, input, 1: single clock.
- `rst_in`, input, 1: reset, synchronous, active-high.
- `clear_in`, input, 1: abort the current query; empty the list and return to FILL.
- `data_valid_in`, input, 1: candidate present; connects to `distance.data_valid_out`.
- `distance_sq_in`, input, 32: IEEE-754 single-precision squared distance.
- `vertex_id_in`, input, ID_WIDTH: ID of the candidate vertex.
- `last_in`, input, 1: qualified by `data_valid_in`; marks the final candidate of the query.
- `data_ready_out`, output, 1: high in FILL; candidates presented while low are ignored.
- `result_valid_out`, output, 1: a result beat is present.
- `result_ready_in`, input, 1: consumer accepts the beat.
- `result_distance_out`, output, 32: distance of the current beat.
- `result_id_out`, output, ID_WIDTH: ID of the current beat.
- `result_last_out`, output, 1: the current beat is the final one.
- `count_out`, output, $clog2(K+1): number of occupied slots.
- `done_out`, output, 1: one-cycle pulse when a drain completes.

## Operation
- **Storage:** slots 0..K-1, each holding a valid bit, a distance, and an ID. Valid slots are contiguous from slot 0 and sorted ascending by distance.
- **Compare key:** `distance_sq_in[30:0]` as an unsigned number. The sign bit is ignored, so -0 equals +0. Ordering by bit pattern is correct for non-negative floats.
- **NaN handling:** candidates with exponent 0xFF and a non-zero mantissa are dropped. +Inf is accepted and sorts last.
- **Insertion:** an accepted candidate is placed at position p, the first slot that is invalid or holds a key strictly greater than the candidate. Slots p..K-2 shift to p+1..K-1, and the old slot K-1 is discarded.
  - Ties: a new candidate goes after existing equal keys.
  - If all K slots are valid and no key is strictly greater, the candidate is discarded.
  - Implement as a parallel compare per slot plus a one-cycle shift.
- **`count_out`:** increments on each insertion and saturates at K.
- **FSM states:** FILL, DRAIN, DONE.
  - FILL: `data_ready_out`=1. An accepted candidate with `last_in`=1 is inserted normally. The next state is DRAIN if the post-insert count is > 0; otherwise DONE.
  - DRAIN: read index `idx` starts at 0. Outputs present slot[idx]. `result_last_out` = (`idx` == `count_out`-1). Each cycle with `result_valid_out` && `result_ready_in` increments `idx`. The handshake on the last beat moves to DONE.
  - DONE: `done_out`=1 for exactly one cycle. All slots are invalidated, count returns to 0, and the next state is FILL.
- **`clear_in`:** takes priority over everything in any state. Next cycle: FILL, all slots invalid, `idx`=0, no result or done pulse. A candidate presented in the same cycle as `clear_in` is dropped.
- **Reset values:**
  - State FILL; all slots invalid; `idx`=0.
  - `data_ready_out`=1 after reset releases.
  - `result_valid_out`=0, `result_last_out`=0, `done_out`=0, `count_out`=0.
  - `result_distance_out` and `result_id_out` are 0 whenever `result_valid_out`=0.

## Timing
- A candidate accepted at edge t is visible in the slots and in `count_out` at t+1. One candidate per cycle is sustained, with no bubbles.
- `last_in` accepted at t: `result_valid_out`=1 at t+1 with slot 0.
- For an empty list, `done_out` pulses at t+1 and no beat is sent.
- `result_*` signals must hold stable while `result_valid_out` && !`result_ready_in`. With `result_ready_in` held at 1, K beats take K cycles.
- The final handshake at t gives DONE at t+1 (`done_out`=1, `result_valid_out`=0) and FILL at t+2.
- All outputs are driven from registers or from a mux of registered state. There are no combinational paths from inputs to outputs.
- `rst_in` mid-drain: the next cycle is the reset state; no partial stream resumes.

## Test plan
- **Ordering and ties:** K=4; feed 3.0 (0x40400000, id 1), 1.0 (0x3F800000, id 2), 2.0 (0x40000000, id 3), 1.0 (id 4, `last_in`) -> beats (1.0, 2), (1.0, 4), (2.0, 3), (3.0, 1); `result_last_out` only on beat 4; `done_out` pulses once.
- **Overflow eviction:** K=4; feed 4.0, 3.0, 2.0, 1.0, 0.5, then 5.0 with `last_in` -> beats 0.5, 1.0, 2.0, 3.0; 4.0 and 5.0 discarded; `count_out`=4 throughout the drain.
- **Back-pressure:** drain with `result_ready_in` toggling 1,0,0,1 -> no beat skipped or duplicated; data stable during stalls; `data_ready_out`=0 throughout; `data_valid_in` pulses during the drain are ignored.
- **Special values:** feed NaN (0x7FC00000), -0 (0x80000000), +Inf (0x7F800000, `last_in`) -> beats -0, then +Inf; NaN dropped; `count_out`=2.
- **Edge cases:**
  - A single candidate with `last_in` on an empty list drains one beat with `result_last_out`=1.
  - A NaN with `last_in` on an empty list gives `done_out` at t+1 and no beats.
- **Clear and reset:** `clear_in` asserted mid-drain after beat 2, with a simultaneous candidate -> next cycle in FILL, `count_out`=0, candidate dropped, `done_out` stays 0. Repeat with `rst_in` and get the same result.
